// File: rtl/mem_responder.sv
// Memory-side responder for the CPU rd/wr/addr/data bus: preloadable ROM, read/write RAM,
// programmable read latency, registered tristate drive and sticky error flags.
module mem_responder #(
    parameter int                ADDR_W        = 13,
    parameter int                DATA_W        = 8,
    parameter int                ROM_WORDS     = 256,
    parameter logic [ADDR_W-1:0] RAM_BASE      = 13'h1800,
    parameter int                RAM_WORDS     = 256,
    parameter int                RD_LAT        = 1,
    parameter logic [DATA_W-1:0] UNMAPPED_DATA = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd,
    input  logic                         wr,
    input  logic [ADDR_W-1:0]            addr,
    inout  wire  [DATA_W-1:0]            data,
    input  logic                         ld_en,
    input  logic [$clog2(ROM_WORDS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]            ld_data,
    input  logic                         err_clr,
    output logic                         rd_valid,
    output logic                         wr_err,
    output logic                         conflict_err
);
    localparam int ROM_AW = $clog2(ROM_WORDS);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam logic [ADDR_W:0] ROM_END = (ADDR_W+1)'(ROM_WORDS);
    localparam logic [ADDR_W:0] RAM_LO  = {1'b0, RAM_BASE};
    localparam logic [ADDR_W:0] RAM_HI  = RAM_LO + (ADDR_W+1)'(RAM_WORDS);
    localparam logic [2:0]      LAT_M1  = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;

    logic [DATA_W-1:0] rom_mem [ROM_WORDS];
    logic [DATA_W-1:0] ram_mem [RAM_WORDS];

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_err_q, wr_err_d;
    logic              conflict_q, conflict_d;
    logic              ram_we, wr_err_set, conflict_set;
    logic [ADDR_W-1:0] rd_sel;
    logic [DATA_W-1:0] rd_word;

    // Decode uses the full address width (one extra bit so region ends never wrap).
    function automatic logic is_rom(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < ROM_END;
    endfunction

    function automatic logic is_ram(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= RAM_LO) && ({1'b0, a} < RAM_HI);
    endfunction

    function automatic logic [RAM_AW-1:0] ram_idx(input logic [ADDR_W-1:0] a);
        return RAM_AW'(a - RAM_BASE);
    endfunction

    // Array lookup happens before this edge's preload lands, so a same-edge ld returns old data.
    always_comb begin
        rd_sel = (state_q == IDLE) ? addr : addr_q;
        if (is_rom(rd_sel)) begin
            rd_word = rom_mem[rd_sel[ROM_AW-1:0]];
        end else if (is_ram(rd_sel)) begin
            rd_word = ram_mem[ram_idx(rd_sel)];
        end else begin
            rd_word = UNMAPPED_DATA;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        rd_valid_d   = rd_valid_q;
        ram_we       = 1'b0;
        wr_err_set   = 1'b0;
        conflict_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd && wr) begin
                    conflict_set = 1'b1;
                end else if (rd) begin
                    addr_d = addr;
                    if (RD_LAT == 0) begin
                        state_d    = RD_DRIVE;
                        rdata_d    = rd_word;
                        rd_valid_d = 1'b1;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = RD_WAIT;
                    end
                end else if (wr) begin
                    if (is_ram(addr)) begin
                        ram_we = 1'b1;
                    end else begin
                        wr_err_set = 1'b1;
                    end
                    state_d = WR_HOLD;
                end
            end
            RD_WAIT: begin
                if (!rd) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d    = RD_DRIVE;
                    rdata_d    = rd_word;
                    rd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RD_DRIVE: begin
                if (!rd) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b0;
                end
            end
            WR_HOLD: begin
                if (!wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_err_d   = (wr_err_q & ~err_clr) | wr_err_set;
        conflict_d = (conflict_q & ~err_clr) | conflict_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
            conflict_q <= conflict_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        rdata_q <= rdata_d;
    end

    // Contents survive reset; RAM writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            rom_mem[ld_addr] <= ld_data;
        end
        if (ram_we && reset) begin
            ram_mem[ram_idx(addr)] <= data;
        end
    end

    assign data         = rd_valid_q ? rdata_q : {DATA_W{1'bz}};
    assign rd_valid     = rd_valid_q;
    assign wr_err       = wr_err_q;
    assign conflict_err = conflict_q;

endmodule
